// File: rtl/sqrt_sched_pkg.sv
// Shared definitions for the square-root scheduler: FSM encoding and default widths.
package sqrt_sched_pkg;

   localparam int unsigned DefDw      = 8;
   localparam int unsigned DefRw      = 4;
   localparam int unsigned DefTimeout = 64;

   typedef logic [1:0] state_t;

   localparam state_t StIdle  = 2'd0;
   localparam state_t StIssue = 2'd1;
   localparam state_t StWait  = 2'd2;
   localparam state_t StResp  = 2'd3;

endpackage

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester above 'last', wrapping.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id
);

   logic          hi_found;
   logic          lo_found;
   logic [IW-1:0] hi_id;
   logic [IW-1:0] lo_id;

   // Descending scan leaves the lowest set bit overall and the lowest set bit above 'last'.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (req[k]) begin
            lo_found = 1'b1;
            lo_id    = IW'(k);
            if (k > int'(last)) begin
               hi_found = 1'b1;
               hi_id    = IW'(k);
            end
         end
      end
   end

   always_comb begin
      gnt_id = hi_found ? hi_id : lo_id;
      gnt    = lo_found ? (N'(1) << gnt_id) : '0;
   end

endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one iterative square-root unit between N_REQ requesters with round-robin grants
// and a watchdog that aborts a unit that never reports done.
module sqrt_scheduler
   import sqrt_sched_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DW      = DefDw,
   parameter int unsigned RW      = DefRw,
   parameter int unsigned TIMEOUT = DefTimeout,
   parameter int unsigned IDW     = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    req_ready,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [RW-1:0]       rsp_root,
   output logic                rsp_err,
   output logic                busy,
   output logic                sqrt_go,
   output logic [DW-1:0]       sqrt_sw,
   output logic                sqrt_clr,
   input  logic                sqrt_done,
   input  logic [RW-1:0]       sqrt_root
);

   localparam int unsigned TW = $clog2(TIMEOUT);

   state_t           state_q, state_d;
   logic [DW-1:0]    op_q, op_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [RW-1:0]    root_q, root_d;
   logic             err_q, err_d;
   logic [TW-1:0]    timer_q, timer_d;

   logic [N_REQ-1:0] gnt;
   logic [IDW-1:0]   gnt_id;
   logic [DW-1:0]    sel_data;
   logic             timeout_hit;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IDW)
   ) u_arb (
      .req    (req_valid),
      .last   (last_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         if (gnt_id == IDW'(k)) sel_data = req_data[k*DW +: DW];
      end
   end

   // A done in the final watchdog cycle takes priority over the abort.
   assign timeout_hit = (state_q == StWait) && (timer_q == TW'(TIMEOUT - 1)) && !sqrt_done;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      id_d    = id_q;
      last_d  = last_q;
      root_d  = root_q;
      err_d   = err_q;
      timer_d = timer_q;
      case (state_q)
         StIdle: begin
            if (|req_valid) begin
               op_d    = sel_data;
               id_d    = gnt_id;
               state_d = StIssue;
            end
         end
         StIssue: begin
            timer_d = '0;
            state_d = StWait;
         end
         StWait: begin
            timer_d = timer_q + 1'b1;
            if (sqrt_done) begin
               root_d  = sqrt_root;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (timeout_hit) begin
               root_d  = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               last_d  = id_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= StIdle;
         op_q    <= '0;
         id_q    <= '0;
         last_q  <= IDW'(N_REQ - 1);
         root_q  <= '0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         id_q    <= id_d;
         last_q  <= last_d;
         root_q  <= root_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

   // Outputs are forced low while clr is held, apart from the unit clear.
   assign req_ready = (clr && state_q == StIdle) ? gnt : '0;
   assign sqrt_go   = clr && (state_q == StIssue);
   assign sqrt_sw   = clr ? op_q : '0;
   assign sqrt_clr  = !clr || timeout_hit;
   assign rsp_valid = clr && (state_q == StResp);
   assign rsp_id    = clr ? id_q : '0;
   assign rsp_root  = clr ? root_q : '0;
   assign rsp_err   = clr && err_q;
   assign busy      = clr && (state_q != StIdle);

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Bench for sqrt_scheduler: directed and random transactions against a behavioural model.
module tb_sqrt_scheduler;

   localparam int N = 4;
   localparam int T = 64;

   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_root;
   logic        rsp_err;
   logic        busy;
   logic        sqrt_go;
   logic [7:0]  sqrt_sw;
   logic        sqrt_clr;
   logic        sqrt_done;
   logic [3:0]  sqrt_root;

   int checks = 0;
   int failures = 0;
   int model_last = N - 1;

   sqrt_scheduler #(
      .N_REQ   (4),
      .DW      (8),
      .RW      (4),
      .TIMEOUT (T),
      .IDW     (2)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_root  (rsp_root),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .sqrt_go   (sqrt_go),
      .sqrt_sw   (sqrt_sw),
      .sqrt_clr  (sqrt_clr),
      .sqrt_done (sqrt_done),
      .sqrt_root (sqrt_root)
   );

   always #5 clk = ~clk;

   function automatic int isqrt(input int v);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   function automatic int model_grant(input logic [3:0] mask);
      int idx;
      for (int i = 1; i <= N; i++) begin
         idx = (model_last + i) % N;
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   // Square-root unit model: done u_lat cycles after go unless hung.
   int         u_lat = 10;
   bit         u_hang = 1'b0;
   int         u_cnt = 0;
   logic [7:0] u_op = 8'd0;

   always @(posedge clk) begin
      if (sqrt_clr) u_cnt <= 0;
      else if (sqrt_go) begin
         u_op  <= sqrt_sw;
         u_cnt <= u_lat;
      end else if (u_cnt > 0) u_cnt <= u_cnt - 1;
   end

   assign sqrt_done = (u_cnt == 1) && !u_hang;
   assign sqrt_root = 4'(isqrt(int'(u_op)));

   int go_cnt = 0;
   int clrp_cnt = 0;
   int rdy_cnt = 0;

   always @(negedge clk) begin
      if (sqrt_go) go_cnt++;
      if (sqrt_clr && clr) clrp_cnt++;
      if (req_ready != 4'd0) rdy_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [3:0] mask, input logic [31:0] data, input int lat,
                          input bit hang, input int stall, input logic [3:0] stall_mask,
                          input int exp_id);
      int         g, n, exp_n, go0, clr0, rdy0;
      logic [3:0] oh;
      logic [7:0] op;
      logic [3:0] exp_root;
      bit         exp_err;
      g    = (exp_id >= 0) ? exp_id : model_grant(mask);
      oh   = 4'b0001 << g;
      go0  = go_cnt;
      clr0 = clrp_cnt;
      rdy0 = rdy_cnt;
      u_lat     = lat;
      u_hang    = hang;
      req_valid = mask;
      req_data  = data;
      rsp_ready = 1'b0;
      #1;
      n = 0;
      while (req_ready == 4'd0 && n < 20) begin
         tick();
         n++;
      end
      chk("accept_wait", n, 0);
      chk("accept_ready", req_ready, oh);
      op = 8'(data >> (g * 8));
      tick();
      req_valid = 4'd0;
      chk("issue_go", sqrt_go, 1);
      chk("issue_sw", sqrt_sw, op);
      chk("issue_busy", busy, 1);
      exp_err = hang || (lat > T);
      exp_n   = exp_err ? T + 1 : lat + 1;
      n = 0;
      while (!rsp_valid && n < T + 20) begin
         tick();
         n++;
         if (!rsp_valid) begin
            chk("wait_sw_hold", sqrt_sw, op);
            chk("wait_go_low", sqrt_go, 0);
         end
      end
      exp_root = exp_err ? 4'd0 : 4'(isqrt(int'(op)));
      chk("rsp_latency", n, exp_n);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_root", rsp_root, exp_root);
      chk("rsp_err", rsp_err, exp_err);
      req_valid = stall_mask;
      for (int s = 0; s < stall; s++) begin
         tick();
         chk("stall_valid", rsp_valid, 1);
         chk("stall_id", rsp_id, g);
         chk("stall_root", rsp_root, exp_root);
         chk("stall_err", rsp_err, exp_err);
         chk("stall_no_ready", req_ready, 0);
         chk("stall_no_go", sqrt_go, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_valid = 4'd0;
      chk("post_valid", rsp_valid, 0);
      chk("post_busy", busy, 0);
      chk("go_pulses", go_cnt - go0, 1);
      chk("clr_pulses", clrp_cnt - clr0, exp_err ? 1 : 0);
      chk("ready_pulses", rdy_cnt - rdy0, 1);
      model_last = g;
   endtask

   initial begin
      clr       = 1'b0;
      req_valid = 4'd0;
      req_data  = 32'd0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_sqrt_clr", sqrt_clr, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_go", sqrt_go, 0);
      clr = 1'b1;
      #1;
      chk("rst_sqrt_clr_rel", sqrt_clr, 0);
      chk("rst_sw", sqrt_sw, 0);
      chk("rst_rsp_id", rsp_id, 0);

      // All four at once, each held until accepted: order 0,1,2,3.
      run_txn(4'b1111, 32'h0100_10FF, 10, 1'b0, 0, 4'd0, 0);
      run_txn(4'b1110, 32'h0100_10FF, 10, 1'b0, 0, 4'd0, 1);
      run_txn(4'b1100, 32'h0100_10FF, 10, 1'b0, 0, 4'd0, 2);
      run_txn(4'b1000, 32'h0100_10FF, 10, 1'b0, 0, 4'd0, 3);

      run_txn(4'b0001, 32'h0000_0064, 10, 1'b0, 0, 4'd0, 0);

      // Hung unit, then recovery with 49 on lane 2.
      run_txn(4'b0001, 32'h0000_00AA, 10, 1'b1, 0, 4'd0, 0);
      run_txn(4'b0100, 32'h0031_0000, 10, 1'b0, 0, 4'd0, 2);

      // Long response stall with req1 pending, then req1 goes next.
      run_txn(4'b0001, 32'h0000_0051, 3, 1'b0, 20, 4'b0010, 0);
      run_txn(4'b0010, 32'h0000_0900, 5, 1'b0, 0, 4'd0, 1);

      // Watchdog boundary: done on the last allowed cycle wins, one later aborts.
      run_txn(4'b1000, 32'hE100_0000, 1, 1'b0, 0, 4'd0, 3);
      run_txn(4'b1000, 32'hE100_0000, T, 1'b0, 0, 4'd0, 3);
      run_txn(4'b1000, 32'hE100_0000, T + 1, 1'b0, 0, 4'd0, 3);

      for (int i = 0; i < 8; i++) begin
         run_txn(4'b0101, $urandom, 2, 1'b0, 0, 4'd0, (i % 2 == 0) ? 0 : 2);
      end

      for (int i = 0; i < 30; i++) begin
         run_txn(4'($urandom_range(1, 15)), $urandom, int'($urandom_range(1, 12)), 1'b0,
                 int'($urandom_range(0, 3)), 4'($urandom), -1);
      end

      // Reset in the middle of WAIT.
      req_valid = 4'b0100;
      req_data  = 32'h00C8_0000;
      u_lat     = 30;
      u_hang    = 1'b0;
      #1;
      chk("mw_ready", req_ready, 4'b0100);
      tick();
      req_valid = 4'd0;
      tick();
      tick();
      chk("mw_busy", busy, 1);
      chk("mw_no_rsp", rsp_valid, 0);
      clr = 1'b0;
      #1;
      chk("mw_clr_out", sqrt_clr, 1);
      chk("mw_busy_gated", busy, 0);
      tick();
      clr = 1'b1;
      #1;
      chk("mw_busy_after", busy, 0);
      chk("mw_rsp_after", rsp_valid, 0);
      chk("mw_go_after", sqrt_go, 0);
      chk("mw_sw_after", sqrt_sw, 0);
      chk("mw_clr_after", sqrt_clr, 0);
      chk("mw_id_after", rsp_id, 0);
      chk("mw_err_after", rsp_err, 0);
      model_last = N - 1;
      run_txn(4'b1001, 32'h0300_0019, 4, 1'b0, 0, 4'd0, 0);
      run_txn(4'b1000, 32'h0300_0019, 4, 1'b0, 0, 4'd0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
